core_rdout_buf: RTL and testbench

CORE_RDOUT_BUF -- requirements
Module: core_rdout_buf

---
 rtl/core_rdout_pkg.sv | 26 ++
 rtl/core_rdout_fifo.sv | 54 +++++
 rtl/core_rdout_buf.sv | 105 ++++++++++
 tb/tb_core_rdout_buf.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_rdout_pkg.sv
// Shared sizing for the read-out buffer: counter/pointer widths and depth check.
// Used by core_rdout_buf and core_rdout_fifo (optional CORE_RDOUT_BYPASS_EN lives in the top).
package core_rdout_pkg;

    localparam int unsigned FIFODPT_DEF = 4;
    localparam int unsigned BITFIFO_DEF = 2;

    function automatic int unsigned cnt_w(input int unsigned bitfifo);
        return bitfifo + 1;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned bitfifo);
        return bitfifo;
    endfunction

    typedef logic [cnt_w(BITFIFO_DEF)-1:0] cnt_t;
    typedef logic [ptr_w(BITFIFO_DEF)-1:0] ptr_t;

    function automatic bit fifo_cfg_ok(
        input int unsigned dpt,
        input int unsigned bitfifo
    );
        return (dpt >= 2) && (dpt == (32'd1 << bitfifo));
    endfunction

endpackage

// File: rtl/core_rdout_fifo.sv
// Single-port-pair synchronous FIFO; a pop in the same cycle frees room for a push.
// Pushes into a full FIFO without a pop are ignored (the caller flags them).
module core_rdout_fifo
    import core_rdout_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FIFODPT = FIFODPT_DEF,
    parameter int BITFIFO = BITFIFO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int CW = cnt_w(BITFIFO);
    localparam int PW = ptr_w(BITFIFO);
    localparam logic [CW-1:0] DPT = CW'(FIFODPT);

    logic [WIDTH-1:0] mem [FIFODPT];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == DPT);
    assign empty   = (occ == '0);
    assign head    = mem[rptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // Pointers are power-of-two wide, so wrap comes for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            occ <= occ + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/core_rdout_buf.sv
// Credit-based read-out buffer between requesters and a fixed-latency core read path.
// Define CORE_RDOUT_BYPASS_EN for zero-latency forwarding into an empty FIFO.
module core_rdout_buf
    import core_rdout_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUMRDPT = 2,
    parameter int BITADDR = 13,
    parameter int FIFODPT = FIFODPT_DEF,
    parameter int BITFIFO = BITFIFO_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2*NUMRDPT-1:0]           rqst_read,
    input  logic [2*NUMRDPT*BITADDR-1:0]   rqst_rdaddr,
    output logic [2*NUMRDPT-1:0]           rqst_rdy,
    output logic [2*NUMRDPT-1:0]           vread,
    output logic [2*NUMRDPT*BITADDR-1:0]   vrdaddr,
    input  logic [2*NUMRDPT-1:0]           vread_vld,
    input  logic [2*NUMRDPT*WIDTH-1:0]     vdout,
    output logic [2*NUMRDPT-1:0]           rd_vld,
    output logic [2*NUMRDPT*WIDTH-1:0]     rd_dout,
    input  logic [2*NUMRDPT-1:0]           rd_rdy,
    output logic [2*NUMRDPT-1:0]           rd_err
);

    localparam int P  = 2 * NUMRDPT;
    localparam int CW = cnt_w(BITFIFO);
    localparam logic [CW-1:0] DPT = CW'(FIFODPT);

    if (!fifo_cfg_ok(FIFODPT, BITFIFO)) begin : g_cfg_err
        $error("core_rdout_buf: FIFODPT must be 2**BITFIFO and >= 2");
    end

    assign vrdaddr = rqst_rdaddr;

    for (genvar p = 0; p < P; p++) begin : g_port
        logic [CW-1:0]    cnt;
        logic             err;
        logic             full;
        logic             empty;
        logic [WIDTH-1:0] head;
        logic [WIDTH-1:0] data;
        logic             unsol;
        logic             push_ok;
        logic             byp;
        logic             vld;
        logic             pop;
        logic             f_push;
        logic             f_pop;

        assign rqst_rdy[p] = (cnt < DPT);
        assign vread[p]    = rqst_read[p] & rqst_rdy[p] & ~rst;
        assign unsol       = vread_vld[p] & (cnt == '0);
        assign push_ok     = vread_vld[p] & ~unsol;

`ifdef CORE_RDOUT_BYPASS_EN
        assign byp  = push_ok & empty;
        assign data = empty ? vdout[p*WIDTH +: WIDTH] : head;
`else
        assign byp  = 1'b0;
        assign data = head;
`endif

        assign vld    = ~empty | byp;
        assign pop    = vld & rd_rdy[p];
        assign f_pop  = rd_rdy[p] & ~empty;
        assign f_push = push_ok & ~(byp & rd_rdy[p]);

        assign rd_vld[p]                 = vld;
        assign rd_dout[p*WIDTH +: WIDTH] = vld ? data : '0;
        assign rd_err[p]                 = err;

        core_rdout_fifo #(
            .WIDTH   (WIDTH),
            .FIFODPT (FIFODPT),
            .BITFIFO (BITFIFO)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (f_push),
            .din   (vdout[p*WIDTH +: WIDTH]),
            .pop   (f_pop),
            .full  (full),
            .empty (empty),
            .head  (head)
        );

        // cnt tracks reads in flight plus entries held for the consumer.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                err <= 1'b0;
            end else begin
                unique case ({vread[p], pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
                err <= err | unsol | (push_ok & full & ~f_pop);
            end
        end
    end

endmodule

// File: tb/tb_core_rdout_buf.sv
// Bench for core_rdout_buf: queue-based per-port model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_core_rdout_buf;

    localparam int W  = 32;
    localparam int NP = 2;
    localparam int P  = 2 * NP;
    localparam int BA = 13;
    localparam int FD = 4;
    localparam int BF = 2;
`ifdef CORE_RDOUT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [P-1:0]    rqst_read;
    logic [P*BA-1:0] rqst_rdaddr;
    logic [P-1:0]    rqst_rdy;
    logic [P-1:0]    vread;
    logic [P*BA-1:0] vrdaddr;
    logic [P-1:0]    vread_vld;
    logic [P*W-1:0]  vdout;
    logic [P-1:0]    rd_vld;
    logic [P*W-1:0]  rd_dout;
    logic [P-1:0]    rd_rdy;
    logic [P-1:0]    rd_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [P][$];
    int           mcnt [P];
    bit           merr [P];

    always #5 clk = ~clk;

    core_rdout_buf #(
        .WIDTH   (W),
        .NUMRDPT (NP),
        .BITADDR (BA),
        .FIFODPT (FD),
        .BITFIFO (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rqst_read   (rqst_read),
        .rqst_rdaddr (rqst_rdaddr),
        .rqst_rdy    (rqst_rdy),
        .vread       (vread),
        .vrdaddr     (vrdaddr),
        .vread_vld   (vread_vld),
        .vdout       (vdout),
        .rd_vld      (rd_vld),
        .rd_dout     (rd_dout),
        .rd_rdy      (rd_rdy),
        .rd_err      (rd_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < P; p++) begin
            mq[p].delete();
            mcnt[p] = 0;
            merr[p] = 1'b0;
        end
    endtask

    function automatic bit model_byp(input int p);
        return BYP && vread_vld[p] && mcnt[p] != 0 && mq[p].size() == 0;
    endfunction

    task automatic model_step(input int p);
        bit iss;
        bit byp;
        bit vld;
        bit pop;
        logic [W-1:0] d;
        d   = vdout[p*W +: W];
        iss = rqst_read[p] && (mcnt[p] < FD);
        byp = model_byp(p);
        vld = (mq[p].size() != 0) || byp;
        pop = vld && rd_rdy[p];
        if (pop && !byp) void'(mq[p].pop_front());
        if (vread_vld[p]) begin
            if (mcnt[p] == 0) merr[p] = 1'b1;
            else if (byp) begin
                if (!rd_rdy[p]) mq[p].push_back(d);
            end else if (mq[p].size() >= FD) merr[p] = 1'b1;
            else mq[p].push_back(d);
        end
        mcnt[p] = mcnt[p] + int'(iss) - int'(pop);
    endtask

    always @(posedge clk) begin
        if (rst) model_clear();
        else for (int p = 0; p < P; p++) model_step(p);
    end

    // Every cycle: compare DUT outputs against the model's view.
    always @(negedge clk) begin
        if (rst) model_clear();
        for (int p = 0; p < P; p++) begin
            bit           e_rdy;
            bit           e_vld;
            logic [W-1:0] e_dout;
            e_rdy = (mcnt[p] < FD);
            e_vld = 1'b0;
            e_dout = '0;
            if (mq[p].size() != 0) begin
                e_vld = 1'b1;
                e_dout = mq[p][0];
            end else if (model_byp(p)) begin
                e_vld = 1'b1;
                e_dout = vdout[p*W +: W];
            end
            chk($sformatf("cyc_rdy%0d", p), 64'(rqst_rdy[p]), 64'(e_rdy));
            chk($sformatf("cyc_vread%0d", p), 64'(vread[p]),
                64'(rqst_read[p] & e_rdy & ~rst));
            chk($sformatf("cyc_vld%0d", p), 64'(rd_vld[p]), 64'(e_vld));
            chk($sformatf("cyc_dout%0d", p), 64'(rd_dout[p*W +: W]), 64'(e_dout));
            chk($sformatf("cyc_err%0d", p), 64'(rd_err[p]), 64'(merr[p]));
            chk($sformatf("cyc_addr%0d", p), 64'(vrdaddr[p*BA +: BA]),
                64'(rqst_rdaddr[p*BA +: BA]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        rqst_read   = '1;
        rqst_rdaddr = '0;
        vread_vld   = '0;
        vdout       = '0;
        rd_rdy      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 64'(rqst_rdy), 64'hF);
        chk("rst_vread", 64'(vread), 64'h0);
        chk("rst_vld", 64'(rd_vld), 64'h0);
        chk("rst_err", 64'(rd_err), 64'h0);
        chk("rst_dout", 64'(rd_dout[63:0]), 64'h0);
        rst       = 1'b0;
        rqst_read = '0;
        step();

        // single request, return two cycles later
        rd_rdy[0] = 1'b1;
        rqst_read[0] = 1'b1;
        rqst_rdaddr[0 +: BA] = 13'h123;
        #1 chk("a_vread", 64'(vread[0]), 64'h1);
        chk("a_addr", 64'(vrdaddr[0 +: BA]), 64'h123);
        step();
        rqst_read[0] = 1'b0;
        step();
        vread_vld[0] = 1'b1;
        vdout[0 +: W] = 32'hA5A5A5A5;
        #1 chk("a_vld_ret", 64'(rd_vld[0]), 64'(BYP));
        step();
        vread_vld[0] = 1'b0;
        #1 chk("a_vld_next", 64'(rd_vld[0]), 64'(!BYP));
        chk("a_dout_next", 64'(rd_dout[0 +: W]), BYP ? 64'h0 : 64'hA5A5A5A5);
        step();
        #1 chk("a_vld_done", 64'(rd_vld[0]), 64'h0);
        chk("a_rdy_done", 64'(rqst_rdy[0]), 64'h1);

        // credit exhaustion on port 2
        for (int i = 0; i < 5; i++) begin
            rqst_read[2] = 1'b1;
            #1 chk($sformatf("b_vread_%0d", i), 64'(vread[2]), 64'(i < 4));
            if (i == 4) chk("b_rdy_5th", 64'(rqst_rdy[2]), 64'h0);
            step();
        end
        rqst_read[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vread_vld[2] = 1'b1;
            vdout[2*W +: W] = 32'h100 + 32'(i);
            step();
        end
        vread_vld[2] = 1'b0;
        #1 chk("b_vld", 64'(rd_vld[2]), 64'h1);
        chk("b_head", 64'(rd_dout[2*W +: W]), 64'h100);
        chk("b_err", 64'(rd_err[2]), 64'h0);
        chk("b_rdy", 64'(rqst_rdy[2]), 64'h0);

        // full: pop with a blocked request, then pop and issue together
        rqst_read[2] = 1'b1;
        rd_rdy[2] = 1'b1;
        #1 chk("c_vread_blk", 64'(vread[2]), 64'h0);
        chk("c_head0", 64'(rd_dout[2*W +: W]), 64'h100);
        step();
        #1 chk("c_rdy", 64'(rqst_rdy[2]), 64'h1);
        chk("c_vread", 64'(vread[2]), 64'h1);
        chk("c_head1", 64'(rd_dout[2*W +: W]), 64'h101);
        step();
        rqst_read[2] = 1'b0;
        rd_rdy[2] = 1'b0;
        vread_vld[2] = 1'b1;
        vdout[2*W +: W] = 32'h104;
        #1 chk("c_rdy_same", 64'(rqst_rdy[2]), 64'h1);
        step();
        vread_vld[2] = 1'b0;
        rqst_read[2] = 1'b1;
        #1 chk("c_vread2", 64'(vread[2]), 64'h1);
        step();
        rqst_read[2] = 1'b0;
        vread_vld[2] = 1'b1;
        vdout[2*W +: W] = 32'h105;
        step();
        vdout[2*W +: W] = 32'hDEAD;
        #1 chk("c_err_pre", 64'(rd_err[2]), 64'h0);
        step();
        vread_vld[2] = 1'b0;
        #1 chk("c_err_full", 64'(rd_err[2]), 64'h1);
        chk("c_head_kept", 64'(rd_dout[2*W +: W]), 64'h102);
        chk("c_rdy_full", 64'(rqst_rdy[2]), 64'h0);
        rd_rdy[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("c_drain_%0d", i), 64'(rd_dout[2*W +: W]), 64'h102 + 64'(i));
            step();
        end
        rd_rdy[2] = 1'b0;
        #1 chk("c_empty", 64'(rd_vld[2]), 64'h0);
        chk("c_rdy_empty", 64'(rqst_rdy[2]), 64'h1);

        // unsolicited return on port 1
        vread_vld[1] = 1'b1;
        vdout[1*W +: W] = 32'hBAD1;
        step();
        vread_vld[1] = 1'b0;
        #1 chk("d_err1", 64'(rd_err[1]), 64'h1);
        chk("d_err0", 64'(rd_err[0]), 64'h0);
        chk("d_err3", 64'(rd_err[3]), 64'h0);
        chk("d_vld1", 64'(rd_vld[1]), 64'h0);
        step();
        #1 chk("d_err1_held", 64'(rd_err[1]), 64'h1);

        // reset with reads outstanding on port 3
        rqst_read[3] = 1'b1;
        repeat (3) step();
        rqst_read[3] = 1'b0;
        vread_vld[3] = 1'b1;
        vdout[3*W +: W] = 32'h333;
        step();
        vread_vld[3] = 1'b0;
        #1 chk("e_vld_pre", 64'(rd_vld[3]), 64'h1);
        rst = 1'b1;
        #1 chk("e_vld_rst", 64'(rd_vld), 64'h0);
        chk("e_rdy_rst", 64'(rqst_rdy), 64'hF);
        chk("e_err_rst", 64'(rd_err), 64'h0);
        step();
        rst = 1'b0;
        step();
        vread_vld[3] = 1'b1;
        vdout[3*W +: W] = 32'h444;
        step();
        vread_vld[3] = 1'b0;
        #1 chk("e_err_late", 64'(rd_err[3]), 64'h1);
        chk("e_err_other", 64'(rd_err[2:0]), 64'h0);

        // return into empty FIFO with consumer ready
        rqst_read[0] = 1'b1;
        step();
        rqst_read[0] = 1'b0;
        vread_vld[0] = 1'b1;
        vdout[0 +: W] = 32'h1234;
        #1 chk("f_vld_same", 64'(rd_vld[0]), 64'(BYP));
        chk("f_dout_same", 64'(rd_dout[0 +: W]), BYP ? 64'h1234 : 64'h0);
        step();
        vread_vld[0] = 1'b0;
        #1 chk("f_vld_next", 64'(rd_vld[0]), 64'(!BYP));
        chk("f_dout_next", 64'(rd_dout[0 +: W]), BYP ? 64'h0 : 64'h1234);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
